pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Generates hold/flush for the PC and the
//  IF/ID, ID/EX, EX/MEM registers from load-use hazards, fixed-latency mul/div, memory wait states
//  and EX-stage redirects. Holds a pending redirect across memory waits. Counts stall cycles.
// PARAMETERS
//  MD_CYCLES  4   EX cycles a mul/div occupies (>=2); EX holds for MD_CYCLES-1 extra cycles
//  CNT_W      32  width of perf_stall_cnt
// PORTS
//  clk             in   1      clock
//  rst_n           in   1      async active-low reset
//  id_rs1, id_rs2  in   5      source regs of instr in ID
//  id_use_rs1/2    in   1      ID instr reads rs1 / rs2
//  ex_rd           in   5      dest reg of instr in EX
//  ex_memread      in   1      EX instr is a load
//  ex_md           in   1      EX instr is mul/div (valid in first EX cycle)
//  ex_redirect     in   1      EX resolved taken branch / jump
//  ex_target       in   32     redirect target
//  im_wait, dm_wait in  1      instruction / data memory not ready this cycle
//  pc_hold         out  1      PC keeps its value
//  pc_redirect     out  1      PC loads pc_target this cycle
//  pc_target       out  32     redirect target (live ex_target or latched)
//  if_id_stall, if_id_flush  out 1   IF/ID control (flush wins over stall in register)
//  id_ex_stall, id_ex_flush  out 1   ID/EX control
//  ex_mem_stall, ex_mem_flush out 1  EX/MEM control
//  mem_wb_stall    out  1      MEM/WB hold
//  perf_stall_cnt  out  CNT_W  cycles with pc_hold=1 and pc_redirect=0
// BEHAVIOUR
//  - Reset: state=RUN, md_cnt=0, pend_valid=0, pend_target=0, perf_stall_cnt=0. All control
//    outputs combinational; with no hazards every output=0, pc_target=ex_target.
//  - FSM RUN / MD_BUSY / REDIR_PEND. Priority per cycle, highest first:
//    1 mem_wait = im_wait|dm_wait: all *_stall=1, pc_hold=1, no flush, pc_redirect=0. If
//      ex_redirect=1 in RUN: latch pend_target<=ex_target, go REDIR_PEND. MD counter frozen.
//    2 REDIR_PEND, no mem_wait: pc_redirect=1, pc_target=pend_target, if_id_flush=1,
//      id_ex_flush=1; next RUN, pend_valid<=0. Exactly one cycle.
//    3 MD_BUSY: pc_hold, if_id_stall, id_ex_stall=1, ex_mem_flush=1 (bubble to MEM);
//      md_cnt++; when md_cnt==MD_CYCLES-2 -> RUN, md_cnt<=0 (EX released next cycle).
//    4 RUN, ex_redirect: pc_redirect=1, pc_target=ex_target, if_id_flush=1, id_ex_flush=1;
//      load-use ignored (ID instr killed). A redirecting instr is never ex_md.
//    5 RUN, ex_md (and no mem_wait): same outputs as MD_BUSY, md_cnt<=0, go MD_BUSY.
//    6 RUN, load-use: ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) |
//      (id_use_rs2 & id_rs2==ex_rd)): pc_hold=1, if_id_stall=1, id_ex_flush=1. One bubble.
//  - x0 never creates a hazard. rs1==rs2==ex_rd: still one bubble.
//  - perf_stall_cnt: +1 on every pc_hold=1 & pc_redirect=0 cycle; wraps at 2^CNT_W.
//  - Async reset mid-MD or mid-REDIR_PEND: drop to RUN at once, pending redirect discarded.
// STRUCTURE
//  - Package cpu_ctrl_pkg: typedef enum logic [1:0] {HZ_RUN, HZ_MD_BUSY, HZ_REDIR_PEND},
//    REG_ZERO = 5'd0, NOP_INSTR = 32'h00000013.
//  - Sub-module hazard_loaduse_detect: pure comb compare of id_rs*/ex_rd -> load_use.
//  - Top: FSM, md_cnt ($clog2(MD_CYCLES) bits), pend_target reg, perf counter, output mux.
// TESTING
//  1 Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> 1 cycle pc_hold, if_id_stall,
//    id_ex_flush; next cycle all 0; perf_stall_cnt=1.
//  2 x0: ex_memread=1, ex_rd=0, id_rs1=0, id_use_rs1=1 -> no stall.
//  3 MD, MD_CYCLES=4: ex_md=1 at t0 -> stalls/ex_mem_flush at t0..t2, clear t3; dm_wait at
//    t1 extends to t3, clear t4.
//  4 Redirect: ex_redirect=1, ex_target=0x100, ex_memread hazard also present -> pc_redirect,
//    pc_target=0x100, both flushes, no pc_hold.
//  5 Redirect under wait: ex_redirect=1, target 0x200, im_wait=1 for 3 cycles -> stalls only;
//    cycle 4: pc_redirect=1, pc_target=0x200, flushes; cycle 5 quiet.
//  6 Reset asserted in MD_BUSY then in REDIR_PEND -> outputs 0, counter 0, no redirect later.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_ctrl_pkg
// Purpose : Shared types and constants for the pipeline control logic.
//           Provides the hazard sequencer state encoding, the architectural
//           zero register index and the canonical NOP encoding used for
//           bubbles.
// Ports   : (package, no ports)
// Revision: 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN        = 2'd0,
        HZ_MD_BUSY    = 2'd1,
        HZ_REDIR_PEND = 2'd2
    } hz_state_e;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_loaduse_detect.sv
`default_nettype none
// ============================================================================
// Module  : hazard_loaduse_detect
// Purpose : Purely combinational load-use hazard detector. Flags when the
//           instruction in ID reads a register that the load in EX has not
//           yet written back. x0 is hard-wired and never forms a hazard.
// Ports   : id_rs1_i, id_rs2_i        - source registers of the ID instruction
//           id_use_rs1_i, id_use_rs2_i - ID instruction actually reads rs1/rs2
//           ex_rd_i                   - destination register of EX instruction
//           ex_memread_i              - EX instruction is a load
//           load_use_o                - hazard present this cycle
// Revision: 1.0 - initial release
// ============================================================================
module hazard_loaduse_detect
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_memread_i,
    output logic       load_use_o
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    assign w_rs2_hit  = id_use_rs2_i && (id_rs2_i == ex_rd_i);
    assign load_use_o = ex_memread_i && (ex_rd_i != REG_ZERO) && (w_rs1_hit || w_rs2_hit);

endmodule : hazard_loaduse_detect
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Purpose : Central stall/flush sequencer for the 5-stage pipeline. Resolves
//           memory wait states, pending redirects, multi-cycle mul/div,
//           EX-stage redirects and load-use hazards (in that priority) into
//           hold/flush controls for the PC and pipeline registers, and counts
//           stall cycles.
// Ports   : clk, rst_n                  - clock, async active-low reset
//           id_rs1_i/id_rs2_i/id_use_*  - ID-stage operand usage
//           ex_rd_i, ex_memread_i       - EX-stage load destination
//           ex_md_i                     - EX instr is mul/div (first EX cycle)
//           ex_redirect_i, ex_target_i  - EX-resolved taken branch / jump
//           im_wait_i, dm_wait_i        - memory not ready this cycle
//           pc_hold_o, pc_redirect_o, pc_target_o - PC control
//           *_stall_o, *_flush_o        - pipeline register control
//           perf_stall_cnt_o            - cycles with PC held and no redirect
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_memread_i,
    input  logic             ex_md_i,
    input  logic             ex_redirect_i,
    input  logic [31:0]      ex_target_i,
    input  logic             im_wait_i,
    input  logic             dm_wait_i,
    output logic             pc_hold_o,
    output logic             pc_redirect_o,
    output logic [31:0]      pc_target_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_stall_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_stall_o,
    output logic             ex_mem_flush_o,
    output logic             mem_wb_stall_o,
    output logic [CNT_W-1:0] perf_stall_cnt_o
);

    localparam int MD_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
    // MD_BUSY covers the extra EX cycles after the first (spent in RUN);
    // leave once the post-increment count reaches MD_CYCLES-2.
    localparam int             c_md_last_i = (MD_CYCLES > 2) ? (MD_CYCLES - 2) : 1;
    localparam logic [MD_W-1:0] c_md_last  = MD_W'(c_md_last_i);

    hz_state_e        state_q, state_d;
    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic             pend_valid_q, pend_valid_d;
    logic [31:0]      pend_target_q, pend_target_d;
    logic [CNT_W-1:0] perf_q, perf_d;

    logic             w_load_use;
    logic             w_mem_wait;
    logic [MD_W-1:0]  w_md_inc;

    hazard_loaduse_detect u_loaduse (
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .id_use_rs1_i (id_use_rs1_i),
        .id_use_rs2_i (id_use_rs2_i),
        .ex_rd_i      (ex_rd_i),
        .ex_memread_i (ex_memread_i),
        .load_use_o   (w_load_use)
    );

    assign w_mem_wait = im_wait_i | dm_wait_i;
    assign w_md_inc   = md_cnt_q + MD_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HZ_RUN;
            md_cnt_q      <= '0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'd0;
            perf_q        <= '0;
        end else begin
            state_q       <= state_d;
            md_cnt_q      <= md_cnt_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            perf_q        <= perf_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        md_cnt_d       = md_cnt_q;
        pend_valid_d   = pend_valid_q;
        pend_target_d  = pend_target_q;
        pc_hold_o      = 1'b0;
        pc_redirect_o  = 1'b0;
        pc_target_o    = pend_valid_q ? pend_target_q : ex_target_i;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        ex_mem_flush_o = 1'b0;
        mem_wb_stall_o = 1'b0;

        if (w_mem_wait) begin
            // Whole pipe freezes; the mul/div counter is frozen by simply
            // not advancing it. A redirect seen now is parked until the
            // wait clears so the PC update is not lost.
            pc_hold_o      = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_stall_o  = 1'b1;
            ex_mem_stall_o = 1'b1;
            mem_wb_stall_o = 1'b1;
            if ((state_q == HZ_RUN) && ex_redirect_i) begin
                pend_target_d = ex_target_i;
                pend_valid_d  = 1'b1;
                state_d       = HZ_REDIR_PEND;
            end
        end else begin
            case (state_q)
                HZ_REDIR_PEND: begin
                    pc_redirect_o = 1'b1;
                    pc_target_o   = pend_target_q;
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                    pend_valid_d  = 1'b0;
                    state_d       = HZ_RUN;
                end
                HZ_MD_BUSY: begin
                    // EX is occupied: hold front end, send a bubble to MEM.
                    pc_hold_o      = 1'b1;
                    if_id_stall_o  = 1'b1;
                    id_ex_stall_o  = 1'b1;
                    ex_mem_flush_o = 1'b1;
                    md_cnt_d       = w_md_inc;
                    if (w_md_inc == c_md_last) begin
                        md_cnt_d = '0;
                        state_d  = HZ_RUN;
                    end
                end
                default: begin
                    if (ex_redirect_i) begin
                        // The ID instruction is killed, so any load-use
                        // hazard it would have caused is irrelevant.
                        pc_redirect_o = 1'b1;
                        pc_target_o   = ex_target_i;
                        if_id_flush_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                    end else if (ex_md_i) begin
                        pc_hold_o      = 1'b1;
                        if_id_stall_o  = 1'b1;
                        id_ex_stall_o  = 1'b1;
                        ex_mem_flush_o = 1'b1;
                        md_cnt_d       = '0;
                        // With MD_CYCLES==2 the single extra cycle is this one.
                        if (MD_CYCLES > 2) begin
                            state_d = HZ_MD_BUSY;
                        end
                    end else if (w_load_use) begin
                        pc_hold_o     = 1'b1;
                        if_id_stall_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                    end
                end
            endcase
        end

        perf_d = perf_q;
        if (pc_hold_o && !pc_redirect_o) begin
            perf_d = perf_q + CNT_W'(1);
        end
    end

    assign perf_stall_cnt_o = perf_q;

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Purpose : Directed testbench for pipeline_hazard_ctrl. The stimulus process
//           drives one cycle of inputs and queues the hand-derived expected
//           controls; a monitor pops and compares each cycle on the falling
//           edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_memread, ex_md, ex_redirect;
    logic [31:0] ex_target;
    logic        im_wait, dm_wait;
    logic        pc_hold, pc_redirect;
    logic [31:0] pc_target;
    logic        if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        ex_mem_stall, ex_mem_flush, mem_wb_stall;
    logic [31:0] perf_cnt;

    pipeline_hazard_ctrl #(.MD_CYCLES(4), .CNT_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_rs1_i         (id_rs1),
        .id_rs2_i         (id_rs2),
        .id_use_rs1_i     (id_use_rs1),
        .id_use_rs2_i     (id_use_rs2),
        .ex_rd_i          (ex_rd),
        .ex_memread_i     (ex_memread),
        .ex_md_i          (ex_md),
        .ex_redirect_i    (ex_redirect),
        .ex_target_i      (ex_target),
        .im_wait_i        (im_wait),
        .dm_wait_i        (dm_wait),
        .pc_hold_o        (pc_hold),
        .pc_redirect_o    (pc_redirect),
        .pc_target_o      (pc_target),
        .if_id_stall_o    (if_id_stall),
        .if_id_flush_o    (if_id_flush),
        .id_ex_stall_o    (id_ex_stall),
        .id_ex_flush_o    (id_ex_flush),
        .ex_mem_stall_o   (ex_mem_stall),
        .ex_mem_flush_o   (ex_mem_flush),
        .mem_wb_stall_o   (mem_wb_stall),
        .perf_stall_cnt_o (perf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector order:
    // {pc_hold, pc_redirect, if_id_stall, if_id_flush, id_ex_stall,
    //  id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_stall}
    localparam logic [8:0] c_none = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] c_lu   = 9'b1_0_1_0_0_1_0_0_0;
    localparam logic [8:0] c_md   = 9'b1_0_1_0_1_0_0_1_0;
    localparam logic [8:0] c_wait = 9'b1_0_1_0_1_0_1_0_1;
    localparam logic [8:0] c_red  = 9'b0_1_0_1_0_1_0_0_0;

    typedef struct {
        string       nm;
        logic [8:0]  ctrl;
        logic [31:0] tgt;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_cnt = 32'd0;
    logic        stim_done = 1'b0;

    // Monitor: compare DUT against the queued expectation every falling edge.
    always @(negedge clk) begin
        exp_t       e;
        logic [8:0] got;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = {pc_hold, pc_redirect, if_id_stall, if_id_flush, id_ex_stall,
                   id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_stall};
            n_tests++;
            if (got !== e.ctrl) begin
                n_fail++;
                $display("FAIL %s ctrl: got %b expected %b", e.nm, got, e.ctrl);
            end
            n_tests++;
            if (pc_target !== e.tgt) begin
                n_fail++;
                $display("FAIL %s pc_target: got %h expected %h", e.nm, pc_target, e.tgt);
            end
            n_tests++;
            if (perf_cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s perf_cnt: got %0d expected %0d", e.nm, perf_cnt, e.cnt);
            end
        end
    end

    task automatic quiet();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_memread = 1'b0; ex_md = 1'b0; ex_redirect = 1'b0;
        im_wait = 1'b0; dm_wait = 1'b0;
    endtask

    // Queue expectation for the current cycle, then advance one clock.
    task automatic cyc(input string nm, input logic [8:0] ctrl, input logic [31:0] tgt);
        exp_t e;
        e.nm = nm; e.ctrl = ctrl; e.tgt = tgt; e.cnt = model_cnt;
        sb_q.push_back(e);
        if (ctrl[8] && !ctrl[7]) model_cnt = model_cnt + 32'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        quiet();
        ex_target = 32'hDEAD_0000;
        @(posedge clk); #1;
        cyc("reset", c_none, 32'hDEAD_0000);
        rst_n = 1'b1;
        cyc("idle", c_none, 32'hDEAD_0000);

        // Load-use on rs1, then the bubble cycle is quiet
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        cyc("lu_rs1", c_lu, 32'hDEAD_0000);
        quiet();
        cyc("lu_after", c_none, 32'hDEAD_0000);

        // Load-use on rs2; rs2 match ignored when not used
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        cyc("lu_rs2", c_lu, 32'hDEAD_0000);
        id_use_rs2 = 1'b0;
        cyc("lu_rs2_unused", c_none, 32'hDEAD_0000);

        // rs1==rs2==ex_rd still one bubble
        ex_rd = 5'd9; id_rs1 = 5'd9; id_rs2 = 5'd9; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        cyc("lu_both", c_lu, 32'hDEAD_0000);
        quiet();
        cyc("lu_both_after", c_none, 32'hDEAD_0000);

        // x0 never hazards; non-load never hazards
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        cyc("x0", c_none, 32'hDEAD_0000);
        ex_memread = 1'b0; ex_rd = 5'd3; id_rs1 = 5'd3;
        cyc("no_load", c_none, 32'hDEAD_0000);
        quiet();

        // Mul/div: t0..t2 stalled, t3 clear
        ex_md = 1'b1;
        cyc("md_t0", c_md, 32'hDEAD_0000);
        ex_md = 1'b0;
        cyc("md_t1", c_md, 32'hDEAD_0000);
        cyc("md_t2", c_md, 32'hDEAD_0000);
        cyc("md_t3", c_none, 32'hDEAD_0000);

        // Mul/div with dm_wait at t1: freeze, then t2..t3 busy, t4 clear
        ex_md = 1'b1;
        cyc("mdw_t0", c_md, 32'hDEAD_0000);
        ex_md = 1'b0; dm_wait = 1'b1;
        cyc("mdw_t1", c_wait, 32'hDEAD_0000);
        dm_wait = 1'b0;
        cyc("mdw_t2", c_md, 32'hDEAD_0000);
        cyc("mdw_t3", c_md, 32'hDEAD_0000);
        cyc("mdw_t4", c_none, 32'hDEAD_0000);

        // Redirect beats a simultaneous load-use hazard
        ex_redirect = 1'b1; ex_target = 32'h0000_0100;
        ex_memread = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_use_rs1 = 1'b1;
        cyc("redir", c_red, 32'h0000_0100);
        quiet();
        cyc("redir_after", c_none, 32'h0000_0100);

        // Redirect under 3 cycles of im_wait, target held while ex_target moves
        ex_redirect = 1'b1; ex_target = 32'h0000_0200; im_wait = 1'b1;
        cyc("rw_c1", c_wait, 32'h0000_0200);
        ex_redirect = 1'b0; ex_target = 32'h0000_0333;
        cyc("rw_c2", c_wait, 32'h0000_0200);
        cyc("rw_c3", c_wait, 32'h0000_0200);
        im_wait = 1'b0;
        cyc("rw_c4", c_red, 32'h0000_0200);
        cyc("rw_c5", c_none, 32'h0000_0333);

        // Async reset in MD_BUSY
        ex_md = 1'b1;
        cyc("rst_md_t0", c_md, 32'h0000_0333);
        ex_md = 1'b0;
        rst_n = 1'b0; model_cnt = 32'd0;
        cyc("rst_md_in", c_none, 32'h0000_0333);
        rst_n = 1'b1;
        cyc("rst_md_after", c_none, 32'h0000_0333);

        // Async reset in REDIR_PEND discards the pending redirect
        ex_redirect = 1'b1; ex_target = 32'h0000_0444; dm_wait = 1'b1;
        cyc("rst_rp_c1", c_wait, 32'h0000_0444);
        ex_redirect = 1'b0; ex_target = 32'h0000_0555; dm_wait = 1'b0;
        rst_n = 1'b0; model_cnt = 32'd0;
        cyc("rst_rp_in", c_none, 32'h0000_0555);
        rst_n = 1'b1;
        cyc("rst_rp_after1", c_none, 32'h0000_0555);
        cyc("rst_rp_after2", c_none, 32'h0000_0555);

        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!(stim_done && sb_q.size() == 0) && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        if (budget >= 2000) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: pending %0d expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
